// File: rtl/vend_dispense_ctrl.sv
// Dispense sequencer: soda motor handshake, then one-nickel-at-a-time change ejection.
// Coin acceptance is inhibited while busy, and any handshake timeout latches a fault.
module vend_dispense_ctrl #(
    parameter  int unsigned TIMEOUT_CYC = 1000,
    localparam int unsigned TW          = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_vend_valid,
    input  logic       i_soda,
    input  logic [2:0] i_change,
    output logic       o_vend_ready,
    output logic       o_soda_motor,
    input  logic       i_soda_done,
    output logic       o_nickel_eject,
    input  logic       i_nickel_ack,
    output logic       o_coin_inhibit,
    output logic       o_done,
    output logic       o_fault,
    input  logic       i_fault_clr
);

    typedef enum logic [2:0] {
        IDLE,
        SODA,
        EJECT,
        GAP,
        DONE,
        FAULT
    } state_t;

    localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYC - 1);

    state_t        state, state_nxt;
    logic [2:0]    rem, rem_nxt;
    logic [TW-1:0] timer, timer_nxt;

    always_comb begin
        state_nxt = state;
        rem_nxt   = rem;
        timer_nxt = timer;
        case (state)
            IDLE: begin
                if (i_vend_valid) begin
                    rem_nxt   = i_change;
                    timer_nxt = '0;
                    if (i_soda)
                        state_nxt = SODA;
                    else if (i_change != '0)
                        state_nxt = EJECT;
                    else
                        state_nxt = DONE;
                end
            end
            SODA: begin
                if (i_soda_done) begin
                    timer_nxt = '0;
                    state_nxt = (rem != '0) ? EJECT : DONE;
                end else if (timer == LAST) begin
                    state_nxt = FAULT;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            EJECT: begin
                // Handshake is checked before expiry so an ack on the last allowed cycle wins.
                if (i_nickel_ack) begin
                    rem_nxt   = rem - 3'd1;
                    state_nxt = GAP;
                end else if (timer == LAST) begin
                    state_nxt = FAULT;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            GAP: begin
                timer_nxt = '0;
                state_nxt = (rem != '0) ? EJECT : DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            FAULT: begin
                if (i_fault_clr) begin
                    rem_nxt   = '0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state          <= IDLE;
            rem            <= '0;
            timer          <= '0;
            o_vend_ready   <= 1'b1;
            o_soda_motor   <= 1'b0;
            o_nickel_eject <= 1'b0;
            o_coin_inhibit <= 1'b0;
            o_done         <= 1'b0;
            o_fault        <= 1'b0;
        end else begin
            state          <= state_nxt;
            rem            <= rem_nxt;
            timer          <= timer_nxt;
            o_vend_ready   <= (state_nxt == IDLE);
            o_soda_motor   <= (state_nxt == SODA);
            o_nickel_eject <= (state_nxt == EJECT);
            o_coin_inhibit <= (state_nxt != IDLE);
            o_done         <= (state_nxt == DONE);
            o_fault        <= (state_nxt == FAULT);
        end
    end

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Self-checking bench: builds an expected per-cycle output timeline from the dispense rules
// (phase lengths from chosen handshake delays) and replays it against the controller.
module tb_vend_dispense_ctrl;

    localparam int unsigned T = 8;

    // Output vector order: {ready, motor, eject, inhibit, done, fault}
    localparam logic [5:0] O_IDLE  = 6'b100000;
    localparam logic [5:0] O_SODA  = 6'b010100;
    localparam logic [5:0] O_EJ    = 6'b001100;
    localparam logic [5:0] O_GAP   = 6'b000100;
    localparam logic [5:0] O_DONE  = 6'b000110;
    localparam logic [5:0] O_FAULT = 6'b000101;

    typedef struct packed {
        logic       rst_n;
        logic       valid;
        logic       soda;
        logic [2:0] change;
        logic       sdone;
        logic       ack;
        logic       clr;
    } stim_t;

    logic       clk = 1'b0;
    logic       rst_n, vend_valid, soda, soda_done, nickel_ack, fault_clr;
    logic [2:0] change;
    logic       vend_ready, soda_motor, nickel_eject, coin_inhibit, done, fault;

    stim_t      sq[$];
    logic [5:0] vq[$];
    int         nvec = 0;
    int         nerr = 0;
    string      cur  = "none";

    vend_dispense_ctrl #(.TIMEOUT_CYC(T)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_vend_valid  (vend_valid),
        .i_soda        (soda),
        .i_change      (change),
        .o_vend_ready  (vend_ready),
        .o_soda_motor  (soda_motor),
        .i_soda_done   (soda_done),
        .o_nickel_eject(nickel_eject),
        .i_nickel_ack  (nickel_ack),
        .o_coin_inhibit(coin_inhibit),
        .o_done        (done),
        .o_fault       (fault),
        .i_fault_clr   (fault_clr)
    );

    always #5 clk = ~clk;

    function automatic stim_t noise();
        stim_t s;
        s.rst_n  = 1'b1;
        s.valid  = 1'($urandom);
        s.soda   = 1'($urandom);
        s.change = 3'($urandom);
        s.sdone  = 1'($urandom);
        s.ack    = 1'($urandom);
        s.clr    = 1'($urandom);
        return s;
    endfunction

    function automatic stim_t quiet();
        stim_t s = noise();
        s.valid = 1'b0;
        return s;
    endfunction

    // vis is what the outputs show during the cycle in which s is applied.
    task automatic push(input stim_t s, input logic [5:0] vis);
        sq.push_back(s);
        vq.push_back(vis);
    endtask

    // One handshake phase; handshake arrives in cycle d (1-based), d > T never arrives.
    task automatic add_phase(input logic [5:0] vis, input int d, input bit is_soda, output bit faulted);
        stim_t s;
        faulted = 1'b0;
        for (int j = 1; j <= int'(T); j++) begin
            s = noise();
            if (is_soda) s.sdone = (j == d);
            else         s.ack   = (j == d);
            push(s, vis);
            if (j == d) return;
        end
        faulted = 1'b1;
    endtask

    task automatic build_cmd(input bit sd, input int ch, input int ds, input int de[7]);
        stim_t s;
        bit    f = 1'b0;
        s = noise();
        s.valid  = 1'b1;
        s.soda   = sd;
        s.change = 3'(ch);
        push(s, O_IDLE);
        if (sd) add_phase(O_SODA, ds, 1'b1, f);
        for (int i = 0; i < ch && !f; i++) begin
            add_phase(O_EJ, de[i], 1'b0, f);
            if (!f) push(noise(), O_GAP);
        end
        if (f) begin
            repeat ($urandom_range(1, 3)) begin
                s = noise();
                s.clr = 1'b0;
                push(s, O_FAULT);
            end
            s = noise();
            s.clr = 1'b1;
            push(s, O_FAULT);
        end else begin
            push(noise(), O_DONE);
        end
    endtask

    // Entry c's stimulus is applied for one edge; outputs must then match entry c+1's view.
    task automatic run_q();
        logic [5:0] got;
        for (int c = 0; c < sq.size() - 1; c++) begin
            @(negedge clk);
            rst_n      = sq[c].rst_n;
            vend_valid = sq[c].valid;
            soda       = sq[c].soda;
            change     = sq[c].change;
            soda_done  = sq[c].sdone;
            nickel_ack = sq[c].ack;
            fault_clr  = sq[c].clr;
            @(posedge clk);
            #1;
            got = {vend_ready, soda_motor, nickel_eject, coin_inhibit, done, fault};
            nvec++;
            if (got !== vq[c + 1]) begin
                nerr++;
                $display("FAIL %s cycle %0d outputs{rdy,mot,ej,inh,done,flt} got=%b exp=%b",
                         cur, c, got, vq[c + 1]);
            end
        end
        sq.delete();
        vq.delete();
    endtask

    function automatic int rand_d();
        return (($urandom % 12) == 0) ? int'(T) + 1 : int'($urandom_range(1, T));
    endfunction

    task automatic test_reset();
        stim_t s;
        cur = "reset";
        s = noise(); s.rst_n = 1'b0; s.valid = 1'b1; push(s, O_IDLE);
        s = noise(); s.rst_n = 1'b0; s.valid = 1'b1; push(s, O_IDLE);
        push(quiet(), O_IDLE);
        push(quiet(), O_IDLE);
        run_q();
    endtask

    task automatic test_basic();
        int de[7] = '{2, 2, 2, 2, 2, 2, 2};
        cur = "soda_change2";
        build_cmd(1'b1, 2, 3, de);
        push(quiet(), O_IDLE);
        run_q();
    endtask

    task automatic test_zero();
        int de[7] = '{1, 1, 1, 1, 1, 1, 1};
        cur = "zero_cmd";
        build_cmd(1'b0, 0, 1, de);
        push(quiet(), O_IDLE);
        push(quiet(), O_IDLE);
        run_q();
    endtask

    task automatic test_max_change();
        int de[7] = '{1, 1, 1, 1, 1, 1, 1};
        cur = "change7_ack_high";
        build_cmd(1'b0, 7, 1, de);
        push(quiet(), O_IDLE);
        run_q();
    endtask

    task automatic test_timeout();
        int de[7] = '{1, int'(T) + 1, 1, 1, 1, 1, 1};
        cur = "soda_timeout";
        build_cmd(1'b1, 1, int'(T) + 1, de);
        push(quiet(), O_IDLE);
        run_q();
        cur = "eject_timeout";
        build_cmd(1'b0, 3, 1, de);
        push(quiet(), O_IDLE);
        run_q();
    endtask

    task automatic test_expiry_edge();
        int de[7] = '{int'(T), 1, int'(T), 1, 1, 1, 1};
        cur = "handshake_at_expiry";
        build_cmd(1'b1, 3, int'(T), de);
        push(quiet(), O_IDLE);
        run_q();
    endtask

    task automatic test_reset_mid();
        stim_t s;
        int    de[7] = '{2, 1, 3, 1, 1, 1, 1};
        cur = "reset_mid_eject";
        s = noise(); s.valid = 1'b1; s.soda = 1'b0; s.change = 3'd3; push(s, O_IDLE);
        s = noise(); s.ack = 1'b0; s.rst_n = 1'b0; push(s, O_EJ);
        push(quiet(), O_IDLE);
        push(quiet(), O_IDLE);
        build_cmd(1'b1, 2, 2, de);
        push(quiet(), O_IDLE);
        run_q();
    endtask

    task automatic test_back_to_back();
        int de[7];
        cur = "back_to_back_random";
        repeat (40) begin
            foreach (de[i]) de[i] = rand_d();
            build_cmd(1'($urandom), int'($urandom_range(0, 7)), rand_d(), de);
            repeat ($urandom_range(0, 2)) push(quiet(), O_IDLE);
        end
        push(quiet(), O_IDLE);
        run_q();
    endtask

    initial begin
        rst_n      = 1'b0;
        vend_valid = 1'b0;
        soda       = 1'b0;
        change     = '0;
        soda_done  = 1'b0;
        nickel_ack = 1'b0;
        fault_clr  = 1'b0;
        test_reset();
        test_basic();
        test_zero();
        test_max_change();
        test_timeout();
        test_expiry_edge();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/vend_dispense_ctrl.md
Name: vend_dispense_ctrl

Overview:
Sequences the physical dispense actuators after the vending FSM issues a sale. It accepts one vend command (soda flag plus change count in nickels) and drives the soda motor with a done handshake. It then ejects the change one nickel at a time through the coin hopper, using a per-coin acknowledge. It sits between the vending FSM outputs and the actuator pins, inhibits coin acceptance while busy, and latches a fault on any handshake timeout.

Parameters:
TIMEOUT_CYC, 1000, max cycles to wait for i_soda_done or i_nickel_ack before faulting (>=2)
TW, $clog2(TIMEOUT_CYC+1), timeout counter width (derived, not overridden)

Ports:
i_clk  input  1  clock, all logic on rising edge
i_rst_n  input  1  reset; synchronous, active-low
i_vend_valid  input  1  vend command valid
i_soda  input  1  command: dispense one soda
i_change  input  3  command: nickels to return, 0..7
o_vend_ready  output  1  controller can accept a command (state IDLE)
o_soda_motor  output  1  soda motor drive, held until done
i_soda_done  input  1  motor cycle complete
o_nickel_eject  output  1  hopper eject request, held until ack
i_nickel_ack  input  1  one nickel ejected
o_coin_inhibit  output  1  block coin acceptor (all states except IDLE)
o_done  output  1  one-cycle pulse when a command completes
o_fault  output  1  timeout fault latched
i_fault_clr  input  1  clears fault, returns to IDLE

Behaviour:
- Reset (i_rst_n low at edge): state IDLE, remaining count 0, timer 0. Outputs: o_vend_ready=1, all others 0.
- All outputs are registered/Moore, decoded from state only; no input-to-output combinational path.
- States: IDLE, SODA, EJECT, GAP, DONE, FAULT.
- IDLE:
  - Accept when i_vend_valid=1 at an edge (o_vend_ready=1). Latch i_soda and i_change into a 3-bit remaining count rem.
  - Next state: SODA if i_soda=1; else EJECT if i_change!=0; else DONE.
  - i_vend_valid outside IDLE is ignored (not queued).
- SODA: o_soda_motor=1. On i_soda_done=1, go to EJECT if rem!=0, else DONE.
- EJECT: o_nickel_eject=1. On i_nickel_ack=1, rem<=rem-1 and go to GAP.
- GAP: exactly one cycle with eject low. Then go to EJECT if rem!=0, else DONE.
  - i_nickel_ack during GAP is ignored.
  - No underflow possible: EJECT is only entered with rem!=0.
- DONE: o_done=1 for exactly one cycle, then IDLE.
  - Earliest re-accept is the cycle after DONE.
- Timeout:
  - Timer clears on every entry to SODA or EJECT and increments each cycle in those states while the handshake is low.
  - If the timer reaches TIMEOUT_CYC-1 with the handshake still low, go to FAULT.
  - A handshake arriving in the same cycle as timer expiry wins; no fault.
  - Timer saturates and never wraps.
- FAULT:
  - o_fault=1, o_coin_inhibit=1, motor and eject 0, o_vend_ready=0.
  - rem is held for debug readout.
  - On i_fault_clr=1, go to IDLE with rem<=0. i_fault_clr in other states has no effect.
- o_coin_inhibit=1 in SODA, EJECT, GAP, DONE and FAULT.
- Latency, command accepted at edge k:
  - Motor rises at cycle k+1.
  - A zero command (soda=0, change=0) gives o_done at k+1.
- Reset mid-operation: next edge returns to IDLE and drops motor/eject immediately; no completion pulse.
- i_soda_done and i_nickel_ack are level-sampled. Each ack high for one sampled EJECT cycle counts exactly one coin.

Test Plan:
- Reset, then soda=1, change=2; done 3 cycles after motor rises; each ack 2 cycles after eject rises -> motor high 3 cycles, two eject pulses separated by a 1-cycle GAP, o_done one cycle, coin_inhibit high throughout, back to ready.
- Zero command, soda=0, change=0 -> o_done at k+1, no motor or eject activity, ready at k+2.
- soda=0, change=7, ack tied high -> eject pattern high-low x7 (14 cycles), then o_done; rem ends at 0.
- TIMEOUT_CYC=8, soda=1, i_soda_done never asserted -> o_fault rises 8 cycles after motor rises, motor drops. i_vend_valid ignored in FAULT; i_fault_clr returns to IDLE, ready=1.
- Ack in the exact timer-expiry cycle in EJECT -> no fault, proceeds to GAP.
- Reset asserted during EJECT with rem=3 -> next edge all outputs at reset values, o_done never pulses. Next command is processed normally.
